// File: rtl/fft_axi_stream_arb_if.sv
// Stream bundle between NUM_REQ packet sources, the round-robin arbiter and the
// downstream FIFO stage. The master modport is the arbiter's view.
interface fft_axi_stream_arb_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned W       = 32,
    parameter int unsigned ID_W    = 2
);
    logic [NUM_REQ-1:0]   s_valid;
    logic [NUM_REQ*W-1:0] s_data;
    logic [NUM_REQ-1:0]   s_last;
    logic [NUM_REQ-1:0]   s_ready;
    logic                 m_valid;
    logic [W-1:0]         m_data;
    logic                 m_last;
    logic                 m_ready;
    logic [ID_W-1:0]      grant_id;
    logic                 busy;

    modport master (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_last, grant_id, busy
    );

    modport slave (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_last, grant_id, busy
    );
endinterface

// File: rtl/fft_axi_stream_arb.sv
// Round-robin packet arbiter: grants one requester for a whole packet (or until
// the optional beat limit) and passes its beats straight through to the FIFO stage.
module fft_axi_stream_arb #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned W         = 32,
    parameter int unsigned ID_W      = 2,
    parameter int unsigned MAX_BEATS = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    fft_axi_stream_arb_if.master bus_io
);
    localparam int unsigned      CNT_W    = 16;
    localparam logic [CNT_W-1:0] LIMIT_M1 = (MAX_BEATS == 0) ? '0 : CNT_W'(MAX_BEATS - 1);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [ID_W-1:0]  grant_id_q, grant_id_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic             req_found;
    logic [ID_W-1:0]  req_sel;
    logic             g_valid;
    logic             g_last;
    logic [W-1:0]     g_data;
    logic             force_last;
    logic             pkt_end;
    logic             beat_acc;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int unsigned     idx;
        logic [ID_W-1:0] cand;
        req_found = 1'b0;
        req_sel   = rr_ptr_q;
        idx       = 0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(rr_ptr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = ID_W'(idx);
            if (!req_found && bus_io.s_valid[cand]) begin
                req_found = 1'b1;
                req_sel   = cand;
            end
        end
    end

    assign g_valid    = bus_io.s_valid[grant_id_q];
    assign g_last     = bus_io.s_last[grant_id_q];
    assign g_data     = bus_io.s_data[32'(grant_id_q) * W +: W];
    assign force_last = (MAX_BEATS != 0) && (beat_cnt_q == LIMIT_M1);
    assign pkt_end    = g_last | force_last;

    // Next state and the pass-through datapath of the granted requester.
    always_comb begin
        state_d        = state_q;
        grant_id_d     = grant_id_q;
        rr_ptr_d       = rr_ptr_q;
        beat_cnt_d     = beat_cnt_q;
        beat_acc       = 1'b0;
        bus_io.m_valid = 1'b0;
        bus_io.m_data  = '0;
        bus_io.m_last  = 1'b0;
        bus_io.s_ready = '0;

        case (state_q)
            IDLE: begin
                if (req_found) begin
                    grant_id_d = req_sel;
                    beat_cnt_d = '0;
                    state_d    = LOCK;
                end
            end
            LOCK: begin
                bus_io.m_valid             = g_valid;
                bus_io.m_data              = g_data;
                bus_io.m_last              = pkt_end;
                bus_io.s_ready[grant_id_q] = bus_io.m_ready;
                beat_acc                   = g_valid & bus_io.m_ready;
                if (beat_acc) begin
                    if (beat_cnt_q != '1) begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                    if (pkt_end) begin
                        state_d  = IDLE;
                        rr_ptr_d = (grant_id_q == LAST_ID) ? '0 : grant_id_q + ID_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign bus_io.grant_id = grant_id_q;
    assign bus_io.busy     = (state_q == LOCK);
endmodule

// File: tb/tb_fft_axi_stream_arb.sv
// Directed bench for fft_axi_stream_arb: a cycle table plus packet-level sequences
// against an unlimited instance and a MAX_BEATS=4 instance sharing the same inputs.
module tb_fft_axi_stream_arb;
    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   s_valid;
    logic [3:0]   s_last;
    logic [127:0] s_data;
    logic         m_ready;
    bit           obs4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fft_axi_stream_arb_if #(.NUM_REQ(4), .W(32), .ID_W(2)) ifc0 ();
    fft_axi_stream_arb_if #(.NUM_REQ(4), .W(32), .ID_W(2)) ifc4 ();

    assign ifc0.s_valid = s_valid;
    assign ifc0.s_last  = s_last;
    assign ifc0.s_data  = s_data;
    assign ifc0.m_ready = m_ready;
    assign ifc4.s_valid = s_valid;
    assign ifc4.s_last  = s_last;
    assign ifc4.s_data  = s_data;
    assign ifc4.m_ready = m_ready;

    fft_axi_stream_arb #(.NUM_REQ(4), .W(32), .ID_W(2), .MAX_BEATS(0)) dut0 (
        .clk(clk), .rst(rst), .bus_io(ifc0));
    fft_axi_stream_arb #(.NUM_REQ(4), .W(32), .ID_W(2), .MAX_BEATS(4)) dut4 (
        .clk(clk), .rst(rst), .bus_io(ifc4));

    logic        o_mv, o_ml, o_busy;
    logic [31:0] o_md;
    logic [3:0]  o_sr;
    logic [1:0]  o_gid;
    assign o_mv   = obs4 ? ifc4.m_valid  : ifc0.m_valid;
    assign o_ml   = obs4 ? ifc4.m_last   : ifc0.m_last;
    assign o_md   = obs4 ? ifc4.m_data   : ifc0.m_data;
    assign o_sr   = obs4 ? ifc4.s_ready  : ifc0.s_ready;
    assign o_gid  = obs4 ? ifc4.grant_id : ifc0.grant_id;
    assign o_busy = obs4 ? ifc4.busy     : ifc0.busy;

    typedef struct {
        logic [3:0]  sv;
        logic [3:0]  sl;
        logic [31:0] dat;
        logic        mr;
        logic        e_mv;
        logic [31:0] e_md;
        logic        e_ml;
        logic [3:0]  e_sr;
        logic [1:0]  e_gid;
        logic        e_busy;
    } vec_t;

    vec_t vecs [17];

    // Packet sources, downstream ready pattern and observed/expected beat logs.
    int unsigned plen [4];
    int unsigned npkt [4];
    int unsigned start_cyc [4];
    int unsigned beat_i [4];
    int unsigned pkt_i [4];
    logic        mr_pat [$];
    logic [31:0] got_data [$];
    logic        got_last [$];
    logic [1:0]  got_gid [$];
    int          got_cyc [$];
    logic [31:0] tr_md [$];
    logic [3:0]  tr_sr [$];
    logic [31:0] exp_data [$];
    logic        exp_last [$];
    logic [1:0]  exp_gid [$];
    int          exp_cyc [$];

    function automatic vec_t mk(input logic [3:0] sv, input logic [3:0] sl, input logic [31:0] dat,
                                input logic mr, input logic e_mv, input logic [31:0] e_md,
                                input logic e_ml, input logic [3:0] e_sr, input logic [1:0] e_gid,
                                input logic e_busy);
        vec_t v;
        v.sv = sv; v.sl = sl; v.dat = dat; v.mr = mr;
        v.e_mv = e_mv; v.e_md = e_md; v.e_ml = e_ml; v.e_sr = e_sr;
        v.e_gid = e_gid; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycle_end();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        s_valid = '0;
        s_last  = '0;
        s_data  = '0;
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic push_exp(input int r, input logic [31:0] d, input logic l, input int c);
        exp_gid.push_back(2'(r));
        exp_data.push_back(d);
        exp_last.push_back(l);
        exp_cyc.push_back(c);
    endtask

    task automatic clear_logs();
        got_data.delete(); got_last.delete(); got_gid.delete(); got_cyc.delete();
        tr_md.delete(); tr_sr.delete();
        exp_data.delete(); exp_last.delete(); exp_gid.delete(); exp_cyc.delete();
    endtask

    // Drives every requester's packets obeying valid/ready and logs accepted beats.
    task automatic run_traffic(input int unsigned max_cyc);
        int unsigned cyc;
        bit          done;
        cyc = 0;
        for (int r = 0; r < 4; r++) begin
            beat_i[r] = 0;
            pkt_i[r]  = 0;
        end
        forever begin
            done = 1'b1;
            for (int r = 0; r < 4; r++) if (pkt_i[r] < npkt[r]) done = 1'b0;
            if (done) break;
            if (cyc >= max_cyc) begin
                chk("traffic_timeout", 32'(cyc), 32'(max_cyc + 1));
                break;
            end
            for (int r = 0; r < 4; r++) begin
                s_valid[r] = (pkt_i[r] < npkt[r]) && (cyc >= start_cyc[r]);
                s_last[r]  = s_valid[r] && (beat_i[r] == plen[r] - 1);
                s_data[r*32 +: 32] = {8'(r), 8'(pkt_i[r]), 16'(beat_i[r])};
            end
            m_ready = (cyc < 32'(mr_pat.size())) ? mr_pat[cyc] : 1'b1;
            @(negedge clk);
            tr_md.push_back(o_md);
            tr_sr.push_back(o_sr);
            if (o_mv && m_ready) begin
                got_data.push_back(o_md);
                got_last.push_back(o_ml);
                got_gid.push_back(o_gid);
                got_cyc.push_back(int'(cyc));
            end
            for (int r = 0; r < 4; r++) begin
                if (s_valid[r] && o_sr[r]) begin
                    if (beat_i[r] == plen[r] - 1) begin
                        beat_i[r] = 0;
                        pkt_i[r]++;
                    end else begin
                        beat_i[r]++;
                    end
                end
            end
            cycle_end();
            cyc++;
        end
        s_valid = '0;
        s_last  = '0;
        m_ready = 1'b1;
    endtask

    task automatic compare_log(input string name);
        chk({name, "_beats"}, 32'(got_data.size()), 32'(exp_data.size()));
        for (int k = 0; k < exp_data.size() && k < got_data.size(); k++) begin
            chk($sformatf("%s_data%0d", name, k), got_data[k], exp_data[k]);
            chk($sformatf("%s_last%0d", name, k), 32'(got_last[k]), 32'(exp_last[k]));
            chk($sformatf("%s_gid%0d", name, k), 32'(got_gid[k]), 32'(exp_gid[k]));
            chk($sformatf("%s_cyc%0d", name, k), 32'(got_cyc[k]), 32'(exp_cyc[k]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        obs4    = 1'b0;
        rst     = 1'b1;
        s_valid = 4'hF;
        s_last  = 4'hF;
        s_data  = '0;
        m_ready = 1'b1;

        // Reset state with every requester pending.
        @(negedge clk);
        @(negedge clk);
        chk("rst_m_valid", 32'(o_mv), 32'd0);
        chk("rst_m_last", 32'(o_ml), 32'd0);
        chk("rst_s_ready", 32'(o_sr), 32'd0);
        chk("rst_grant_id", 32'(o_gid), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_m_data", o_md, 32'd0);

        // Cycle table: 4-beat packet from 0, rotation/wrap, single beats, stall, bubble.
        vecs[0]  = mk(4'b0001, 4'b0000, 32'h10, 1'b1, 1'b0, 32'h0,        1'b0, 4'b0000, 2'd0, 1'b0);
        vecs[1]  = mk(4'b0001, 4'b0000, 32'h10, 1'b1, 1'b1, 32'h10,       1'b0, 4'b0001, 2'd0, 1'b1);
        vecs[2]  = mk(4'b0001, 4'b0000, 32'h11, 1'b1, 1'b1, 32'h11,       1'b0, 4'b0001, 2'd0, 1'b1);
        vecs[3]  = mk(4'b0001, 4'b0000, 32'h12, 1'b1, 1'b1, 32'h12,       1'b0, 4'b0001, 2'd0, 1'b1);
        vecs[4]  = mk(4'b0001, 4'b0001, 32'h13, 1'b1, 1'b1, 32'h13,       1'b1, 4'b0001, 2'd0, 1'b1);
        vecs[5]  = mk(4'b1001, 4'b1000, 32'h20, 1'b1, 1'b0, 32'h0,        1'b0, 4'b0000, 2'd0, 1'b0);
        vecs[6]  = mk(4'b1001, 4'b1000, 32'h20, 1'b1, 1'b1, 32'h03000020, 1'b1, 4'b1000, 2'd3, 1'b1);
        vecs[7]  = mk(4'b1011, 4'b0011, 32'h30, 1'b1, 1'b0, 32'h0,        1'b0, 4'b0000, 2'd3, 1'b0);
        vecs[8]  = mk(4'b1011, 4'b0011, 32'h30, 1'b1, 1'b1, 32'h30,       1'b1, 4'b0001, 2'd0, 1'b1);
        vecs[9]  = mk(4'b0010, 4'b0010, 32'h40, 1'b1, 1'b0, 32'h0,        1'b0, 4'b0000, 2'd0, 1'b0);
        vecs[10] = mk(4'b0010, 4'b0010, 32'h40, 1'b1, 1'b1, 32'h01000040, 1'b1, 4'b0010, 2'd1, 1'b1);
        vecs[11] = mk(4'b0000, 4'b0000, 32'h0,  1'b1, 1'b0, 32'h0,        1'b0, 4'b0000, 2'd1, 1'b0);
        vecs[12] = mk(4'b0010, 4'b0000, 32'h50, 1'b0, 1'b0, 32'h0,        1'b0, 4'b0000, 2'd1, 1'b0);
        vecs[13] = mk(4'b0010, 4'b0000, 32'h50, 1'b0, 1'b1, 32'h01000050, 1'b0, 4'b0000, 2'd1, 1'b1);
        vecs[14] = mk(4'b0000, 4'b0000, 32'h50, 1'b1, 1'b0, 32'h01000050, 1'b0, 4'b0010, 2'd1, 1'b1);
        vecs[15] = mk(4'b0010, 4'b0010, 32'h50, 1'b1, 1'b1, 32'h01000050, 1'b1, 4'b0010, 2'd1, 1'b1);
        vecs[16] = mk(4'b0000, 4'b0000, 32'h0,  1'b1, 1'b0, 32'h0,        1'b0, 4'b0000, 2'd1, 1'b0);

        do_reset();
        for (int k = 0; k < 17; k++) begin
            s_valid = vecs[k].sv;
            s_last  = vecs[k].sl;
            m_ready = vecs[k].mr;
            for (int i = 0; i < 4; i++) s_data[i*32 +: 32] = vecs[k].dat | (32'(i) << 24);
            @(negedge clk);
            chk($sformatf("vec%0d_m_valid", k), 32'(o_mv), 32'(vecs[k].e_mv));
            chk($sformatf("vec%0d_m_data", k), o_md, vecs[k].e_md);
            chk($sformatf("vec%0d_m_last", k), 32'(o_ml), 32'(vecs[k].e_ml));
            chk($sformatf("vec%0d_s_ready", k), 32'(o_sr), 32'(vecs[k].e_sr));
            chk($sformatf("vec%0d_grant_id", k), 32'(o_gid), 32'(vecs[k].e_gid));
            chk($sformatf("vec%0d_busy", k), 32'(o_busy), 32'(vecs[k].e_busy));
            cycle_end();
        end

        // Reset while requester 2 is mid-packet, after requester 1 moved rr_ptr to 2.
        do_reset();
        s_valid = 4'b0010; s_last = 4'b0010; s_data[32 +: 32] = 32'h01000000;
        cycle_end();
        @(negedge clk);
        chk("rml_first_gid", 32'(o_gid), 32'd1);
        cycle_end();
        s_valid = 4'b0100; s_last = 4'b0000; s_data[64 +: 32] = 32'h02000000;
        cycle_end();
        repeat (3) cycle_end();
        @(negedge clk);
        chk("rml_pre_busy", 32'(o_busy), 32'd1);
        chk("rml_pre_gid", 32'(o_gid), 32'd2);
        rst = 1'b1;
        #1;
        chk("rml_m_valid", 32'(o_mv), 32'd0);
        chk("rml_s_ready", 32'(o_sr), 32'd0);
        chk("rml_grant_id", 32'(o_gid), 32'd0);
        chk("rml_busy", 32'(o_busy), 32'd0);
        cycle_end();
        rst = 1'b0;
        s_valid = 4'b0110; s_last = 4'b0110;
        @(negedge clk);
        chk("rml_idle_busy", 32'(o_busy), 32'd0);
        cycle_end();
        @(negedge clk);
        chk("rml_regrant_gid", 32'(o_gid), 32'd1);
        chk("rml_regrant_sready", 32'(o_sr), 32'b0010);
        cycle_end();

        // Downstream stall during a 3-beat packet from requester 1.
        do_reset();
        clear_logs();
        plen = '{1, 3, 1, 1}; npkt = '{0, 1, 0, 0}; start_cyc = '{0, 0, 0, 0};
        mr_pat.delete();
        mr_pat.push_back(1'b1); mr_pat.push_back(1'b1); mr_pat.push_back(1'b0);
        mr_pat.push_back(1'b0); mr_pat.push_back(1'b1); mr_pat.push_back(1'b1);
        run_traffic(20);
        push_exp(1, 32'h01000000, 1'b0, 1);
        push_exp(1, 32'h01000001, 1'b0, 4);
        push_exp(1, 32'h01000002, 1'b1, 5);
        compare_log("stall");
        chk("stall_trace_len", 32'(tr_sr.size()), 32'd6);
        if (tr_sr.size() == 6) begin
            chk("stall_sready_c1", 32'(tr_sr[1]), 32'b0010);
            chk("stall_sready_c2", 32'(tr_sr[2]), 32'b0000);
            chk("stall_sready_c3", 32'(tr_sr[3]), 32'b0000);
            chk("stall_sready_c4", 32'(tr_sr[4]), 32'b0010);
            chk("stall_data_c2", tr_md[2], 32'h01000001);
            chk("stall_data_c3", tr_md[3], 32'h01000001);
        end

        // All four requesters continuously valid with 2-beat packets.
        do_reset();
        clear_logs();
        mr_pat.delete();
        plen = '{2, 2, 2, 2}; npkt = '{2, 2, 2, 2}; start_cyc = '{0, 0, 0, 0};
        run_traffic(60);
        for (int k = 0; k < 8; k++) begin
            for (int b = 0; b < 2; b++) begin
                push_exp(k % 4, {8'(k % 4), 8'(k / 4), 16'(b)}, b == 1, 3 * k + 1 + b);
            end
        end
        compare_log("fair");

        // Beat limit 4: requester 3 sends 10 beats, requester 0 joins while it is granted.
        do_reset();
        clear_logs();
        obs4 = 1'b1;
        mr_pat.delete();
        plen = '{1, 1, 1, 10}; npkt = '{1, 0, 0, 1}; start_cyc = '{2, 0, 0, 0};
        run_traffic(60);
        for (int b = 0; b < 4; b++) push_exp(3, {8'd3, 8'd0, 16'(b)}, b == 3, 1 + b);
        push_exp(0, 32'h00000000, 1'b1, 6);
        for (int b = 4; b < 8; b++) push_exp(3, {8'd3, 8'd0, 16'(b)}, b == 7, 4 + b);
        push_exp(3, 32'h03000008, 1'b0, 13);
        push_exp(3, 32'h03000009, 1'b1, 14);
        compare_log("maxb");
        obs4 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fft_axi_stream_arb.md
Name: fft_axi_stream_arb

Overview:
- Round-robin packet arbiter that shares one valid/ready stream channel among NUM_REQ requesters (e.g. FFT sample sources).
- Sits upstream of the FFT AXI input path and drives the 2-deep register FIFO stage in front of the FFT core.
- Grant is held for a whole packet, from the first beat to the accepted last beat, so packets never interleave.
- An optional beat limit stops any single requester from holding the channel indefinitely.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- W, 32, data width per beat.
- ID_W, 2, width of grant index; 2^ID_W >= NUM_REQ required.
- MAX_BEATS, 0, forced-release beat limit per grant; 0 = unlimited (release only on last).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- s_valid  input  NUM_REQ  per-requester beat valid.
- s_data  input  NUM_REQ*W  packed data; requester i at [i*W +: W].
- s_last  input  NUM_REQ  per-requester end-of-packet flag.
- s_ready  output  NUM_REQ  per-requester ready.
- m_valid  output  1  downstream valid.
- m_data  output  W  downstream data.
- m_last  output  1  downstream last; also asserted on forced release.
- m_ready  input  1  downstream ready.
- grant_id  output  ID_W  index of the current/last granted requester.
- busy  output  1  high while in LOCK.

Behaviour:
- Reset: state IDLE, grant_id=0, rr_ptr=0, beat_cnt=0, busy=0. m_valid, m_last and all s_ready are 0 while rst=1 and in IDLE. m_data=0 in IDLE.
- Registers: state, grant_id, rr_ptr (ID_W), beat_cnt (16 bits, saturating).
- IDLE:
  - m_valid=0, all s_ready=0.
  - If any s_valid is set, select the first set requester searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Register the selection into grant_id, clear beat_cnt, go to LOCK.
  - Arbitration latency: 1 cycle (first beat can transfer at the earliest in the cycle after the request is seen).
- LOCK (g = grant_id):
  - m_valid = s_valid[g], m_data = s_data[g], s_ready[g] = m_ready; other s_ready = 0.
  - m_last = s_last[g] | (MAX_BEATS!=0 & beat_cnt==MAX_BEATS-1).
  - Beat accepted = m_valid & m_ready; each accepted beat increments beat_cnt.
  - Accepted beat with m_last=1: go to IDLE, rr_ptr <= (g+1) mod NUM_REQ (wraps from NUM_REQ-1 to 0).
  - Otherwise stay in LOCK. The granted requester dropping s_valid mid-packet does not release the grant (bubble only).
- Requesters not granted see s_ready=0 and must hold data stable (valid/ready rule). The arbiter never drops or duplicates a beat.
- Downstream stall: m_ready=0 holds state, beat_cnt and the presented beat unchanged.
- Single-beat packet (s_last on first beat): LOCK for exactly one accepted beat, then IDLE.
- Back-to-back packets: 1 idle cycle between packets (IDLE re-arbitration). Full throughput within a packet.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0,...
- Forced release: requester's next beats start a new packet on a later grant; its s_last semantics are unchanged.
- Reset asserted mid-packet: immediate return to the reset state. Partial packet is abandoned (downstream FIFO is reset on the same rst).
- grant_id holds its value in IDLE. busy = (state==LOCK).

Test Plan:
- Reset mid-LOCK (requester 2, beat 3 of 8): rst pulse -> m_valid=0, s_ready=0000, grant_id=0, busy=0 in the same cycle; next packet arbitrated from rr_ptr=0.
- Single requester: s_valid=0001, 4-beat packet data 0x10..0x13, m_ready=1 -> grant at cycle 1, beats on m_data in cycles 1-4, m_last in cycle 4, IDLE in cycle 5, rr_ptr=1.
- All four requesters continuously valid, 2-beat packets -> grant_id sequence 0,1,2,3,0. No interleaving. 1 gap cycle between packets.
- Downstream stall: m_ready toggles 1,0,0,1 during a 3-beat packet from requester 1 -> m_data held during stall, s_ready[1] mirrors m_ready, exactly 3 beats delivered in order.
- MAX_BEATS=4, requester 3 sends a 10-beat packet, requester 0 also valid -> m_last forced on beat 4, grant moves to 0, then requester 3 resumes with beats 5-8.
- Single-beat packets from requesters 1 and 3 (s_last=1 on the first beat) -> each LOCK lasts one beat. Wrap check: grant 3 then rr_ptr=0.
